// File: rtl/register_file_param.sv
// Parameterised two-read/one-write register file with per-entry valid bits,
// optional hardwired-zero register 0 and optional write-to-read forwarding.
module register_file_param #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 3,
  parameter int ZERO_REG  = 0,
  parameter int BYPASS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic [ADDR_BITS-1:0] i_reg_read_0,
  input  logic [ADDR_BITS-1:0] i_reg_read_1,
  input  logic [ADDR_BITS-1:0] i_reg_write,
  input  logic [WIDTH-1:0]     i_port_write,
  input  logic                 i_write_enable,
  output logic [WIDTH-1:0]     o_port_read_0,
  output logic [WIDTH-1:0]     o_port_read_1,
  output logic                 o_valid_read_0,
  output logic                 o_valid_read_1
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [WIDTH-1:0]     regs_q [DEPTH];
  logic [WIDTH-1:0]     regs_d [DEPTH];
  logic [DEPTH-1:0]     valid_q;
  logic [DEPTH-1:0]     valid_d;

  logic                 zero_wr;
  logic                 fwd_en;
  logic [ADDR_BITS-1:0] rd_addr [2];
  logic [WIDTH-1:0]     rd_data [2];
  logic                 rd_valid [2];

  assign rd_addr[0] = i_reg_read_0;
  assign rd_addr[1] = i_reg_read_1;

  assign zero_wr = (ZERO_REG != 0) && (i_reg_write == {ADDR_BITS{1'b0}});
  // Forwarding is suppressed during clear and reset so reads show stored state.
  assign fwd_en  = (BYPASS != 0) && i_write_enable && !i_clear && !i_rst;

  // Next-state storage: clear wins over write; writes to a hardwired r0 are dropped.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    valid_d = valid_q;
    if (i_clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_d[i] = {WIDTH{1'b0}};
      end
      valid_d = {DEPTH{1'b0}};
    end else if (i_write_enable && !zero_wr) begin
      regs_d[i_reg_write]  = i_port_write;
      valid_d[i_reg_write] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Storage registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= {WIDTH{1'b0}};
      end
      valid_q <= {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      valid_q <= valid_d;
    end
  end

  // Combinational read ports: hardwired zero, then forwarding, then storage.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p]  = regs_q[rd_addr[p]];
      rd_valid[p] = valid_q[rd_addr[p]];
      if ((ZERO_REG != 0) && (rd_addr[p] == {ADDR_BITS{1'b0}})) begin
        rd_data[p]  = {WIDTH{1'b0}};
        rd_valid[p] = 1'b1;
      end else if (fwd_en && (rd_addr[p] == i_reg_write)) begin
        rd_data[p]  = i_port_write;
        rd_valid[p] = 1'b1;
      end else begin
        rd_data[p]  = regs_q[rd_addr[p]];
        rd_valid[p] = valid_q[rd_addr[p]];
      end
    end
  end

  assign o_port_read_0  = rd_data[0];
  assign o_port_read_1  = rd_data[1];
  assign o_valid_read_0 = rd_valid[0];
  assign o_valid_read_1 = rd_valid[1];

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: three configurations driven in parallel and
// compared against an array-based reference model, directed cases then random.
module tb_register_file_param;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       we;
  logic [2:0] ra0;
  logic [2:0] ra1;
  logic [2:0] wa;
  logic [7:0] wd;

  // index 0: ZERO_REG=0 BYPASS=1, 1: ZERO_REG=0 BYPASS=0, 2: ZERO_REG=1 BYPASS=1
  logic [7:0] d0 [3];
  logic [7:0] d1 [3];
  logic       v0 [3];
  logic       v1 [3];

  int checks_cnt = 0;
  int errors_cnt = 0;

  logic [7:0] mem [8];
  logic       vld [8];

  register_file_param #(.WIDTH(8), .ADDR_BITS(3), .ZERO_REG(0), .BYPASS(1)) dut_byp (
    .i_clk(clk), .i_rst(rst), .i_clear(clr),
    .i_reg_read_0(ra0), .i_reg_read_1(ra1), .i_reg_write(wa),
    .i_port_write(wd), .i_write_enable(we),
    .o_port_read_0(d0[0]), .o_port_read_1(d1[0]),
    .o_valid_read_0(v0[0]), .o_valid_read_1(v1[0])
  );

  register_file_param #(.WIDTH(8), .ADDR_BITS(3), .ZERO_REG(0), .BYPASS(0)) dut_nobyp (
    .i_clk(clk), .i_rst(rst), .i_clear(clr),
    .i_reg_read_0(ra0), .i_reg_read_1(ra1), .i_reg_write(wa),
    .i_port_write(wd), .i_write_enable(we),
    .o_port_read_0(d0[1]), .o_port_read_1(d1[1]),
    .o_valid_read_0(v0[1]), .o_valid_read_1(v1[1])
  );

  register_file_param #(.WIDTH(8), .ADDR_BITS(3), .ZERO_REG(1), .BYPASS(1)) dut_zero (
    .i_clk(clk), .i_rst(rst), .i_clear(clr),
    .i_reg_read_0(ra0), .i_reg_read_1(ra1), .i_reg_write(wa),
    .i_port_write(wd), .i_write_enable(we),
    .o_port_read_0(d0[2]), .o_port_read_1(d1[2]),
    .o_valid_read_0(v0[2]), .o_valid_read_1(v1[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < 8; i++) begin
      mem[i] = 8'h00;
      vld[i] = 1'b0;
    end
  endtask

  // Expected read for configuration k at address a, from the current inputs.
  task automatic exp_read(input int k, input logic [2:0] a,
                          output logic [7:0] ed, output logic ev);
    bit zr = (k == 2);
    bit bp = (k != 1);
    if (zr && a == 3'd0) begin
      ed = 8'h00; ev = 1'b1;
    end else if (bp && we && !clr && !rst && a == wa) begin
      ed = wd; ev = 1'b1;
    end else begin
      ed = mem[a]; ev = vld[a];
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] ed;
    logic       ev;
    for (int k = 0; k < 3; k++) begin
      exp_read(k, ra0, ed, ev);
      check_eq($sformatf("%s_c%0d_p0_data", tag, k), {24'h0, d0[k]}, {24'h0, ed});
      check_eq($sformatf("%s_c%0d_p0_valid", tag, k), {31'h0, v0[k]}, {31'h0, ev});
      exp_read(k, ra1, ed, ev);
      check_eq($sformatf("%s_c%0d_p1_data", tag, k), {24'h0, d1[k]}, {24'h0, ed});
      check_eq($sformatf("%s_c%0d_p1_valid", tag, k), {31'h0, v1[k]}, {31'h0, ev});
    end
  endtask

  // Apply inputs on the falling edge and check reads against the model.
  task automatic drive(input logic r, input logic c, input logic w, input logic [2:0] a_w,
                       input logic [7:0] dat, input logic [2:0] a0, input logic [2:0] a1,
                       input string tag);
    @(negedge clk);
    rst = r; clr = c; we = w; wa = a_w; wd = dat; ra0 = a0; ra1 = a1;
    if (r) model_zero();
    #1;
    check_all(tag);
  endtask

  // Advance through the rising edge and update the model accordingly.
  task automatic step();
    @(posedge clk);
    if (!rst) begin
      if (clr) begin
        model_zero();
      end else if (we) begin
        mem[wa] = wd;
        vld[wa] = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; we = 1'b0; wa = 3'd0; wd = 8'h00; ra0 = 3'd0; ra1 = 3'd0;
    model_zero();

    // Reset held with a write attempt: nothing forwarded, nothing stored.
    drive(1'b1, 1'b0, 1'b1, 3'd2, 8'hEE, 3'd2, 3'd0, "rst_hold");
    check_eq("rst_nofwd", {24'h0, d0[0]}, 32'h0);
    step();
    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'(a), 3'(7 - a), "rst_read");
      check_eq("rst_valid0", {31'h0, v0[0]}, 32'h0);
      step();
    end

    // Basic write then read on both ports.
    drive(1'b0, 1'b0, 1'b1, 3'd3, 8'hA5, 3'd0, 3'd1, "wr3"); step();
    drive(1'b0, 1'b0, 1'b1, 3'd5, 8'h3C, 3'd0, 3'd1, "wr5"); step();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd5, "rd35");
    check_eq("rd_r3", {24'h0, d0[0]}, 32'hA5);
    check_eq("rd_r5", {24'h0, d1[0]}, 32'h3C);
    check_eq("rd_v3", {31'h0, v0[0]}, 32'h1);
    step();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd4, "rd4");
    check_eq("rd_v4", {31'h0, v0[0]}, 32'h0);
    step();

    // Forwarding versus no forwarding.
    drive(1'b0, 1'b0, 1'b1, 3'd2, 8'h11, 3'd0, 3'd0, "wr2a"); step();
    drive(1'b0, 1'b0, 1'b1, 3'd2, 8'h77, 3'd2, 3'd2, "byp");
    check_eq("byp_on", {24'h0, d0[0]}, 32'h77);
    check_eq("byp_off", {24'h0, d0[1]}, 32'h11);
    step();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd2, "byp_after");
    check_eq("byp_off_after", {24'h0, d0[1]}, 32'h77);
    step();

    // Hardwired zero register.
    drive(1'b0, 1'b0, 1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, "zr_wr");
    check_eq("zr_during", {24'h0, d0[2]}, 32'h0);
    check_eq("zr_valid", {31'h0, v0[2]}, 32'h1);
    step();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, "zr_after");
    check_eq("zr_after_d", {24'h0, d0[2]}, 32'h0);
    check_eq("r0_plain", {24'h0, d0[0]}, 32'hFF);
    step();

    // Clear wins over a simultaneous write and disables forwarding.
    drive(1'b0, 1'b0, 1'b1, 3'd6, 8'h42, 3'd0, 3'd0, "wr6"); step();
    drive(1'b0, 1'b1, 1'b1, 3'd6, 8'h99, 3'd6, 3'd6, "clr");
    check_eq("clr_during", {24'h0, d0[0]}, 32'h42);
    step();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd6, 3'd6, "clr_after");
    check_eq("clr_after_d", {24'h0, d0[0]}, 32'h0);
    check_eq("clr_after_v", {31'h0, v0[0]}, 32'h0);
    step();

    // Asynchronous reset between edges.
    drive(1'b0, 1'b0, 1'b1, 3'd1, 8'h5A, 3'd0, 3'd0, "wr1"); step();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd1, "pre_rst");
    check_eq("pre_rst_d", {24'h0, d0[0]}, 32'h5A);
    rst = 1'b1;
    model_zero();
    #1;
    check_eq("async_rst_d", {24'h0, d0[0]}, 32'h0);
    check_all("async_rst");
    step();
    drive(1'b0, 1'b0, 1'b1, 3'd1, 8'h33, 3'd0, 3'd0, "post_rst_wr"); step();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd1, "post_rst_rd");
    check_eq("post_rst_d", {24'h0, d0[0]}, 32'h33);
    step();

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "rand");
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/register_file_param.md
REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- WIDTH, 8: data word width in bits, >=1.
- ADDR_BITS, 3: address width; DEPTH = 2**ADDR_BITS registers.
- ZERO_REG, 0: 1 = register 0 hardwired to zero.
- BYPASS, 1: 1 = write-to-read forwarding in the same cycle.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- i_clk, in, 1: clock, rising edge.
- i_rst, in, 1: reset, asynchronous, active-high.
- i_clear, in, 1: synchronous clear of all registers.
- i_reg_read_0, in, ADDR_BITS: read address, port 0.
- i_reg_read_1, in, ADDR_BITS: read address, port 1.
- i_reg_write, in, ADDR_BITS: write address.
- i_port_write, in, WIDTH: write data.
- i_write_enable, in, 1: write strobe.
- o_port_read_0, out, WIDTH: read data, port 0.
- o_port_read_1, out, WIDTH: read data, port 1.
- o_valid_read_0, out, 1: addressed register written since last reset/clear, port 0.
- o_valid_read_1, out, 1: same, port 1.
REQ-003 Only one clock and one reset SHALL be used; reset is asynchronous and active-high.

Function
REQ-004 Storage SHALL be DEPTH registers of WIDTH bits plus DEPTH valid bits.
REQ-005 On a rising i_clk edge with i_write_enable=1 and i_clear=0, register[i_reg_write] SHALL take i_port_write and its valid bit SHALL set to 1; all other registers hold.
REQ-006 Reads SHALL be combinational: o_port_read_N = register[i_reg_read_N], o_valid_read_N = valid[i_reg_read_N], zero-cycle latency.
REQ-007 Both read ports SHALL be independent; equal read addresses return identical data.
REQ-008 When BYPASS=1, i_write_enable=1, i_clear=0 and i_reg_read_N == i_reg_write, port N SHALL return i_port_write with valid=1 in the same cycle.
REQ-009 When BYPASS=0, a read of the address being written SHALL return the old contents and old valid bit until the next edge.
REQ-010 When ZERO_REG=1, writes to address 0 SHALL be ignored; reads of address 0 SHALL return all zeros with valid=1 regardless of bypass.
REQ-011 i_clear=1 at a rising edge SHALL zero all registers and all valid bits; a simultaneous write SHALL be discarded (clear wins).
REQ-012 While i_clear=1, bypass SHALL be disabled and reads SHALL return current stored contents.
REQ-013 Writes with i_write_enable=0 SHALL have no effect irrespective of address/data.
REQ-014 Address and data inputs SHALL be used unmodified; no wrap or saturation logic is required, since all ADDR_BITS codes are valid indices.

Reset
REQ-015 i_rst=1 SHALL immediately, without a clock edge, zero all registers and valid bits; o_port_read_N SHALL read 0 and o_valid_read_N SHALL read 0 (1 for address 0 when ZERO_REG=1).
REQ-016 While i_rst=1, writes and clears SHALL be ignored; bypass output SHALL still be 0/invalid.
REQ-017 Reset asserted mid-write (between edges) SHALL leave the targeted register at 0 after deassertion.
REQ-018 The first write SHALL be accepted on the first rising edge after i_rst deasserts.

Verification
REQ-019 Benches SHALL cover, with WIDTH=8, ADDR_BITS=3 unless stated:
- Reset: pulse i_rst, read all 8 addresses on both ports -> data 0x00, valid 0.
- Write/read: write 0xA5 to r3, 0x3C to r5; read r3 on port 0 and r5 on port 1 -> 0xA5/0x3C, valid 1/1; r4 -> valid 0.
- Bypass: BYPASS=1, r2 holds 0x11, write 0x77 to r2 while reading r2 on port 0 -> 0x77 same cycle; BYPASS=0 -> 0x11, then 0x77 after the edge.
- Zero register: ZERO_REG=1, write 0xFF to r0 -> read r0 = 0x00, valid 1, also during the write cycle.
- Clear vs write: r6=0x42, assert i_clear with write 0x99 to r6 -> after the edge r6 = 0x00, valid 0; during the cycle port reads 0x42.
- Async reset mid-operation: r1=0x5A, raise i_rst between edges -> o_port_read_0 at r1 becomes 0x00 before the next edge; a write after deassertion is accepted.
